ddr_rd_burst_arbiter: RTL and testbench

- Shares one DDR read-burst master port between NUM_REQ weight-fetch clients, e.g. the Q, K, V and MLP weight FIFOs.
- Each client uses the existing req/addr/len/data/valid/finish burst protocol unchanged.
- Arbitration is round-robin with whole-burst granularity: a granted burst always runs to completion before the next grant.
- Sits between the weight-FIFO instances and the AXI/DDR read engine.

---
 rtl/ddr_rd_burst_arbiter_if.sv | 36 +++
 rtl/ddr_rd_burst_arbiter.sv | 94 +++++++++
 tb/tb_ddr_rd_burst_arbiter.sv | 286 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ddr_rd_burst_arbiter_if.sv
// Client-side and DDR-side read-burst signals shared by the weight-fetch arbiter.
// The master modport is the arbiter's view. The slave modport is the surrounding fabric's view.
interface ddr_rd_burst_arbiter_if #(
  parameter int unsigned NUM_REQ    = 4,
  parameter int unsigned DATA_WIDTH = 64,
  parameter int unsigned ADDR_SIZE  = 32,
  parameter int unsigned LEN_WIDTH  = 10
);
  logic [NUM_REQ-1:0]           c_rd_burst_req;
  logic [NUM_REQ*ADDR_SIZE-1:0] c_rd_burst_addr;
  logic [NUM_REQ*LEN_WIDTH-1:0] c_rd_burst_len;
  logic [DATA_WIDTH-1:0]        c_rd_burst_data;
  logic [NUM_REQ-1:0]           c_rd_burst_valid;
  logic [NUM_REQ-1:0]           c_rd_burst_finish;

  logic                         m_rd_burst_req;
  logic [ADDR_SIZE-1:0]         m_rd_burst_addr;
  logic [LEN_WIDTH-1:0]         m_rd_burst_len;
  logic [DATA_WIDTH-1:0]        m_rd_burst_data;
  logic                         m_rd_burst_valid;
  logic                         m_rd_burst_finish;

  modport master (
    input  c_rd_burst_req, c_rd_burst_addr, c_rd_burst_len,
    output c_rd_burst_data, c_rd_burst_valid, c_rd_burst_finish,
    output m_rd_burst_req, m_rd_burst_addr, m_rd_burst_len,
    input  m_rd_burst_data, m_rd_burst_valid, m_rd_burst_finish
  );

  modport slave (
    output c_rd_burst_req, c_rd_burst_addr, c_rd_burst_len,
    input  c_rd_burst_data, c_rd_burst_valid, c_rd_burst_finish,
    input  m_rd_burst_req, m_rd_burst_addr, m_rd_burst_len,
    output m_rd_burst_data, m_rd_burst_valid, m_rd_burst_finish
  );
endinterface

// File: rtl/ddr_rd_burst_arbiter.sv
// Round-robin, whole-burst arbiter sharing one DDR read-burst port among NUM_REQ weight-fetch clients.
// Each granted burst runs to the DDR finish before the next grant is issued.
module ddr_rd_burst_arbiter #(
  parameter int unsigned NUM_REQ    = 4,
  parameter int unsigned DATA_WIDTH = 64,
  parameter int unsigned ADDR_SIZE  = 32,
  parameter int unsigned LEN_WIDTH  = 10
) (
  input  logic                s_clk,
  input  logic                s_rst_n,
  ddr_rd_burst_arbiter_if.master bus,
  output logic [NUM_REQ-1:0]  o_grant,
  output logic                o_busy
);
  localparam int unsigned IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic [1:0] {IDLE, BUSY, GAP} state_t;

  state_t           state;
  logic [IDX_W-1:0] rr_ptr;
  logic [IDX_W-1:0] grant_idx;
  logic [IDX_W-1:0] pick_idx;
  logic             pick_hit;

  function automatic logic [IDX_W-1:0] wrap_idx(input logic [IDX_W-1:0] base, input int unsigned off);
    int unsigned s;
    s = 32'(base) + off;
    if (s >= NUM_REQ) s = s - NUM_REQ;
    return IDX_W'(s);
  endfunction

  // First requesting client at or after the pointer, scanning modulo NUM_REQ
  always_comb begin
    pick_hit = 1'b0;
    pick_idx = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      if (!pick_hit && bus.c_rd_burst_req[wrap_idx(rr_ptr, k)]) begin
        pick_hit = 1'b1;
        pick_idx = wrap_idx(rr_ptr, k);
      end
    end
  end

  always_ff @(posedge s_clk or negedge s_rst_n) begin
    if (!s_rst_n) begin
      state              <= IDLE;
      rr_ptr             <= '0;
      grant_idx          <= '0;
      o_grant            <= '0;
      o_busy             <= 1'b0;
      bus.m_rd_burst_req  <= 1'b0;
      bus.m_rd_burst_addr <= '0;
      bus.m_rd_burst_len  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (pick_hit) begin
            grant_idx           <= pick_idx;
            o_grant             <= NUM_REQ'(1) << pick_idx;
            bus.m_rd_burst_addr <= bus.c_rd_burst_addr[32'(pick_idx)*ADDR_SIZE +: ADDR_SIZE];
            bus.m_rd_burst_len  <= bus.c_rd_burst_len[32'(pick_idx)*LEN_WIDTH +: LEN_WIDTH];
            bus.m_rd_burst_req  <= 1'b1;
            o_busy              <= 1'b1;
            state               <= BUSY;
          end
        end
        BUSY: begin
          if (bus.m_rd_burst_finish) begin
            bus.m_rd_burst_req <= 1'b0;
            rr_ptr <= (grant_idx == IDX_W'(NUM_REQ - 1)) ? '0 : grant_idx + IDX_W'(1);
            state  <= GAP;
          end
        end
        // One dead cycle lets the finished client drop its request before IDLE samples again
        GAP: begin
          o_grant <= '0;
          o_busy  <= 1'b0;
          state   <= IDLE;
        end
        default: begin
          o_grant            <= '0;
          o_busy             <= 1'b0;
          bus.m_rd_burst_req <= 1'b0;
          state              <= IDLE;
        end
      endcase
    end
  end

  // Return path is combinational; strobes only reach the granted client
  assign bus.c_rd_burst_data   = DATA_WIDTH'(bus.m_rd_burst_data);
  assign bus.c_rd_burst_valid  = o_grant & {NUM_REQ{bus.m_rd_burst_valid}};
  assign bus.c_rd_burst_finish = o_grant & {NUM_REQ{bus.m_rd_burst_finish}};
endmodule

// File: tb/tb_ddr_rd_burst_arbiter.sv
// Directed self-checking bench for ddr_rd_burst_arbiter: reset, single burst, round robin,
// stale request, mid-burst drop, spurious master strobes and asynchronous reset.
module tb_ddr_rd_burst_arbiter;
  localparam int unsigned NUM_REQ    = 4;
  localparam int unsigned DATA_WIDTH = 64;
  localparam int unsigned ADDR_SIZE  = 32;
  localparam int unsigned LEN_WIDTH  = 10;

  logic               s_clk = 1'b0;
  logic               s_rst_n = 1'b1;
  logic [NUM_REQ-1:0] o_grant;
  logic               o_busy;
  int checks = 0;
  int errors = 0;

  ddr_rd_burst_arbiter_if #(.NUM_REQ(NUM_REQ), .DATA_WIDTH(DATA_WIDTH),
                            .ADDR_SIZE(ADDR_SIZE), .LEN_WIDTH(LEN_WIDTH)) bus ();

  ddr_rd_burst_arbiter #(.NUM_REQ(NUM_REQ), .DATA_WIDTH(DATA_WIDTH),
                         .ADDR_SIZE(ADDR_SIZE), .LEN_WIDTH(LEN_WIDTH)) dut (
    .s_clk(s_clk), .s_rst_n(s_rst_n), .bus(bus), .o_grant(o_grant), .o_busy(o_busy));

  always #5 s_clk = ~s_clk;

  // Monitor: per-client beat/finish counts, data sums, grant order and master-req low gaps
  int                 vcnt [NUM_REQ];
  int                 fcnt [NUM_REQ];
  logic [63:0]        dsum [NUM_REQ];
  logic [NUM_REQ-1:0] gq [$];
  int                 min_low;
  int                 low_run;
  logic               prev_req = 1'b0;

  always @(negedge s_clk) begin
    for (int i = 0; i < NUM_REQ; i++) begin
      if (bus.c_rd_burst_valid[i]) begin
        vcnt[i]++;
        dsum[i] += bus.c_rd_burst_data;
      end
      if (bus.c_rd_burst_finish[i]) fcnt[i]++;
    end
    if (bus.m_rd_burst_req && !prev_req) begin
      if (gq.size() > 0 && low_run < min_low) min_low = low_run;
      gq.push_back(o_grant);
    end
    low_run  = bus.m_rd_burst_req ? 0 : low_run + 1;
    prev_req = bus.m_rd_burst_req;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic cyc();
    @(posedge s_clk);
    #1;
  endtask

  task automatic clr_mon();
    for (int i = 0; i < NUM_REQ; i++) begin
      vcnt[i] = 0; fcnt[i] = 0; dsum[i] = '0;
    end
    gq.delete();
    min_low = 1000;
    low_run = 0;
  endtask

  task automatic set_client(input int i, input logic r, input logic [31:0] a, input logic [9:0] l);
    bus.c_rd_burst_req[i] = r;
    bus.c_rd_burst_addr[i*ADDR_SIZE +: ADDR_SIZE] = a;
    bus.c_rd_burst_len[i*LEN_WIDTH +: LEN_WIDTH]  = l;
  endtask

  task automatic zero_inputs();
    bus.c_rd_burst_req    = '0;
    bus.c_rd_burst_addr   = '0;
    bus.c_rd_burst_len    = '0;
    bus.m_rd_burst_data   = '0;
    bus.m_rd_burst_valid  = 1'b0;
    bus.m_rd_burst_finish = 1'b0;
  endtask

  task automatic apply_reset();
    s_rst_n = 1'b0;
    zero_inputs();
    repeat (2) cyc();
    s_rst_n = 1'b1;
    cyc();
    clr_mon();
  endtask

  // Polls up to 20 negedges for master req; lat is the number of negedges waited
  task automatic wait_req(output bit ok, output int lat);
    ok = 1'b0;
    lat = 0;
    for (int n = 1; n <= 20; n++) begin
      @(negedge s_clk);
      if (bus.m_rd_burst_req) begin
        ok = 1'b1;
        lat = n;
        break;
      end
    end
  endtask

  // DDR engine: beats numbered 1..N, then a one-cycle finish; optional client drop at drop_beat
  task automatic do_burst(input int beats, input int drop_beat, input int drop_cl);
    for (int b = 1; b <= beats; b++) begin
      cyc();
      bus.m_rd_burst_valid = 1'b1;
      bus.m_rd_burst_data  = 64'(b);
      if (b == drop_beat) set_client(drop_cl, 1'b0, 32'hDEAD_BEEF, 10'd5);
    end
    cyc();
    bus.m_rd_burst_valid  = 1'b0;
    bus.m_rd_burst_finish = 1'b1;
    cyc();
    bus.m_rd_burst_finish = 1'b0;
  endtask

  task automatic test_reset();
    zero_inputs();
    bus.m_rd_burst_valid = 1'b1;
    #1 s_rst_n = 1'b0;
    repeat (2) @(negedge s_clk);
    checks++; if (bus.m_rd_burst_req !== 1'b0) begin errors++; $display("FAIL reset_m_req: got %0b want 0", bus.m_rd_burst_req); end
    checks++; if (bus.m_rd_burst_addr !== 32'h0) begin errors++; $display("FAIL reset_m_addr: got %h want 0", bus.m_rd_burst_addr); end
    checks++; if (bus.m_rd_burst_len !== 10'd0) begin errors++; $display("FAIL reset_m_len: got %0d want 0", bus.m_rd_burst_len); end
    checks++; if (o_grant !== 4'b0000) begin errors++; $display("FAIL reset_grant: got %b want 0000", o_grant); end
    checks++; if (o_busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %0b want 0", o_busy); end
    checks++; if (dut.rr_ptr !== 2'd0) begin errors++; $display("FAIL reset_ptr: got %0d want 0", dut.rr_ptr); end
    checks++; if (bus.c_rd_burst_valid !== 4'b0000) begin errors++; $display("FAIL reset_c_valid: got %b want 0000", bus.c_rd_burst_valid); end
    bus.m_rd_burst_valid = 1'b0;
    cyc();
    s_rst_n = 1'b1;
    cyc();
    clr_mon();
  endtask

  task automatic test_single();
    bit ok; int lat;
    set_client(2, 1'b1, 32'h0010_0000, 10'd32);
    @(negedge s_clk);
    checks++; if (bus.m_rd_burst_req !== 1'b0) begin errors++; $display("FAIL single_early_req: got %0b want 0", bus.m_rd_burst_req); end
    wait_req(ok, lat);
    checks++; if (!ok || lat != 1) begin errors++; $display("FAIL single_latency: got ok=%0b lat=%0d want ok=1 lat=1", ok, lat); end
    checks++; if (bus.m_rd_burst_addr !== 32'h0010_0000) begin errors++; $display("FAIL single_addr: got %h want 00100000", bus.m_rd_burst_addr); end
    checks++; if (bus.m_rd_burst_len !== 10'd32) begin errors++; $display("FAIL single_len: got %0d want 32", bus.m_rd_burst_len); end
    checks++; if (o_grant !== 4'b0100 || o_busy !== 1'b1) begin errors++; $display("FAIL single_grant: got %b busy=%0b want 0100 busy=1", o_grant, o_busy); end
    do_burst(32, 0, 0);
    bus.c_rd_burst_req[2] = 1'b0;
    @(negedge s_clk);
    checks++; if (bus.m_rd_burst_req !== 1'b0 || o_busy !== 1'b1 || o_grant !== 4'b0100) begin errors++; $display("FAIL single_gap: got req=%0b busy=%0b grant=%b want 0 1 0100", bus.m_rd_burst_req, o_busy, o_grant); end
    @(negedge s_clk);
    checks++; if (o_grant !== 4'b0000 || o_busy !== 1'b0) begin errors++; $display("FAIL single_idle: got grant=%b busy=%0b want 0000 0", o_grant, o_busy); end
    checks++; if (dut.rr_ptr !== 2'd3) begin errors++; $display("FAIL single_ptr: got %0d want 3", dut.rr_ptr); end
    checks++; if (vcnt[2] != 32 || vcnt[0] + vcnt[1] + vcnt[3] != 0) begin errors++; $display("FAIL single_beats: got c2=%0d others=%0d want 32 0", vcnt[2], vcnt[0] + vcnt[1] + vcnt[3]); end
    checks++; if (fcnt[2] != 1 || fcnt[0] + fcnt[1] + fcnt[3] != 0) begin errors++; $display("FAIL single_finish: got c2=%0d others=%0d want 1 0", fcnt[2], fcnt[0] + fcnt[1] + fcnt[3]); end
    checks++; if (dsum[2] !== 64'd528) begin errors++; $display("FAIL single_data: got %0d want 528", dsum[2]); end
  endtask

  task automatic test_round_robin();
    bit ok; int lat; int idx;
    logic [NUM_REQ-1:0] exp_order [5];
    exp_order = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    apply_reset();
    for (int i = 0; i < NUM_REQ; i++) set_client(i, 1'b1, 32'h1000 * 32'(i + 1), 10'd4);
    for (int k = 0; k < 5; k++) begin
      wait_req(ok, lat);
      checks++; if (!ok) begin errors++; $display("FAIL rr_wait%0d: got no grant within 20 cycles want grant", k); end
      idx = (k == 4) ? 0 : k;
      checks++; if (o_grant !== exp_order[k] || bus.m_rd_burst_addr !== 32'h1000 * 32'(idx + 1)) begin
        errors++; $display("FAIL rr_grant%0d: got %b addr=%h want %b addr=%h", k, o_grant, bus.m_rd_burst_addr, exp_order[k], 32'h1000 * 32'(idx + 1)); end
      do_burst(4, 0, 0);
      if (k == 4) bus.c_rd_burst_req = '0;
    end
    repeat (4) @(negedge s_clk);
    #1;
    checks++; if (gq.size() != 5) begin errors++; $display("FAIL rr_count: got %0d bursts want 5", gq.size()); end
    checks++; if (min_low < 2) begin errors++; $display("FAIL rr_gap: got min low %0d cycles want >=2", min_low); end
    checks++; if (vcnt[0] != 8 || vcnt[1] != 4 || vcnt[2] != 4 || vcnt[3] != 4) begin errors++; $display("FAIL rr_beats: got %0d %0d %0d %0d want 8 4 4 4", vcnt[0], vcnt[1], vcnt[2], vcnt[3]); end
    checks++; if (dut.rr_ptr !== 2'd1) begin errors++; $display("FAIL rr_ptr: got %0d want 1", dut.rr_ptr); end
  endtask

  task automatic test_stale();
    bit ok; int lat;
    apply_reset();
    set_client(0, 1'b1, 32'h0000_4000, 10'd4);
    wait_req(ok, lat);
    do_burst(4, 0, 0);
    cyc();
    bus.c_rd_burst_req[0] = 1'b0;
    repeat (6) @(negedge s_clk);
    #1;
    checks++; if (gq.size() != 1 || o_busy !== 1'b0 || bus.m_rd_burst_req !== 1'b0) begin errors++; $display("FAIL stale_no_regrant: got bursts=%0d busy=%0b want 1 0", gq.size(), o_busy); end
    bus.c_rd_burst_req[0] = 1'b1;
    wait_req(ok, lat);
    do_burst(4, 0, 0);
    cyc();
    cyc();
    bus.c_rd_burst_req[0] = 1'b0;
    @(negedge s_clk);
    #1;
    checks++; if (gq.size() != 3 || o_grant !== 4'b0001) begin errors++; $display("FAIL stale_regrant: got bursts=%0d grant=%b want 3 0001", gq.size(), o_grant); end
    do_burst(2, 0, 0);
    repeat (3) cyc();
  endtask

  task automatic test_mid_drop();
    bit ok; int lat;
    apply_reset();
    set_client(1, 1'b1, 32'h2000_0040, 10'd32);
    wait_req(ok, lat);
    checks++; if (!ok || o_grant !== 4'b0010) begin errors++; $display("FAIL drop_grant: got ok=%0b grant=%b want 1 0010", ok, o_grant); end
    do_burst(32, 10, 1);
    @(negedge s_clk);
    checks++; if (bus.m_rd_burst_addr !== 32'h2000_0040 || bus.m_rd_burst_len !== 10'd32) begin errors++; $display("FAIL drop_addr: got %h len=%0d want 20000040 32", bus.m_rd_burst_addr, bus.m_rd_burst_len); end
    checks++; if (vcnt[1] != 32 || fcnt[1] != 1) begin errors++; $display("FAIL drop_route: got beats=%0d finish=%0d want 32 1", vcnt[1], fcnt[1]); end
    checks++; if (vcnt[0] + vcnt[2] + vcnt[3] != 0) begin errors++; $display("FAIL drop_leak: got %0d stray beats want 0", vcnt[0] + vcnt[2] + vcnt[3]); end
    repeat (4) @(negedge s_clk);
    #1;
    checks++; if (gq.size() != 1) begin errors++; $display("FAIL drop_regrant: got bursts=%0d want 1", gq.size()); end
  endtask

  task automatic test_spurious();
    apply_reset();
    bus.m_rd_burst_valid  = 1'b1;
    bus.m_rd_burst_finish = 1'b1;
    bus.m_rd_burst_data   = 64'h1234_5678_9ABC_DEF0;
    @(negedge s_clk);
    checks++; if (bus.c_rd_burst_valid !== 4'b0000 || bus.c_rd_burst_finish !== 4'b0000) begin errors++; $display("FAIL spur_strobes: got v=%b f=%b want 0000 0000", bus.c_rd_burst_valid, bus.c_rd_burst_finish); end
    checks++; if (bus.c_rd_burst_data !== 64'h1234_5678_9ABC_DEF0) begin errors++; $display("FAIL spur_data: got %h want 123456789abcdef0", bus.c_rd_burst_data); end
    cyc();
    bus.m_rd_burst_valid  = 1'b0;
    bus.m_rd_burst_finish = 1'b0;
    @(negedge s_clk);
    checks++; if (o_busy !== 1'b0 || bus.m_rd_burst_req !== 1'b0 || o_grant !== 4'b0000) begin errors++; $display("FAIL spur_state: got busy=%0b req=%0b grant=%b want 0 0 0000", o_busy, bus.m_rd_burst_req, o_grant); end
  endtask

  task automatic test_async_reset();
    bit ok; int lat;
    apply_reset();
    set_client(2, 1'b1, 32'h0030_0000, 10'd4);
    wait_req(ok, lat);
    do_burst(4, 0, 0);
    bus.c_rd_burst_req[2] = 1'b0;
    repeat (2) cyc();
    bus.c_rd_burst_req[2] = 1'b1;
    wait_req(ok, lat);
    checks++; if (!ok || o_grant !== 4'b0100) begin errors++; $display("FAIL areset_pre_grant: got ok=%0b grant=%b want 1 0100", ok, o_grant); end
    for (int b = 1; b <= 5; b++) begin
      cyc();
      bus.m_rd_burst_valid = 1'b1;
      bus.m_rd_burst_data  = 64'(b);
    end
    #2 s_rst_n = 1'b0;
    #1;
    checks++; if (bus.m_rd_burst_req !== 1'b0 || o_grant !== 4'b0000 || o_busy !== 1'b0) begin errors++; $display("FAIL areset_immediate: got req=%0b grant=%b busy=%0b want 0 0000 0", bus.m_rd_burst_req, o_grant, o_busy); end
    checks++; if (bus.c_rd_burst_valid !== 4'b0000 || dut.rr_ptr !== 2'd0) begin errors++; $display("FAIL areset_gate: got v=%b ptr=%0d want 0000 0", bus.c_rd_burst_valid, dut.rr_ptr); end
    bus.m_rd_burst_valid = 1'b0;
    set_client(1, 1'b1, 32'h0050_0000, 10'd2);
    set_client(3, 1'b1, 32'h0070_0000, 10'd2);
    repeat (2) cyc();
    s_rst_n = 1'b1;
    wait_req(ok, lat);
    checks++; if (!ok || o_grant !== 4'b0010 || bus.m_rd_burst_addr !== 32'h0050_0000) begin errors++; $display("FAIL areset_first_grant: got ok=%0b grant=%b addr=%h want 1 0010 00500000", ok, o_grant, bus.m_rd_burst_addr); end
    do_burst(2, 0, 0);
    bus.c_rd_burst_req = '0;
    repeat (3) cyc();
  endtask

  initial begin
    clr_mon();
    test_reset();
    test_single();
    test_round_robin();
    test_stale();
    test_mid_drop();
    test_spurious();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
